// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path: op encoding,
// op classification helpers and default MDU latencies.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int LAT_MULT_DEF = 5;
  localparam int LAT_DIV_DEF  = 10;

  // Any op that touches HI/LO and therefore must wait for the MDU.
  function automatic logic is_md_any(input logic [3:0] op);
    return (op != MD_NONE) && (op <= MD_MTLO);
  endfunction

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter; last_o flags the final busy cycle (count == 1).
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage MD slot, MDU start request, shadow busy tracking with HI/LO
// hazard stall, MDU busy cross-check and stall-cycle performance counter.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int LAT_MULT = LAT_MULT_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        d_md_op,
  input  logic              d_valid,
  input  logic              e_flush,
  input  logic              mdu_busy,
  output logic [3:0]        e_md_op,
  output logic              e_start,
  output logic              stall_d,
  output logic              shadow_busy,
  output logic              busy_mismatch,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [3:0]        e_md_op_q, e_md_op_d;
  md_state_e         state_q, state_d;
  logic              busy_mismatch_q, busy_mismatch_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              run;

  assign run         = (state_q == ST_RUN);
  assign e_md_op     = e_md_op_q;
  assign e_start     = is_md_start(e_md_op_q);
  assign shadow_busy = run;
  assign stall_d     = d_valid & is_md_any(d_md_op) & (e_start | run);

  // Flush and stall both turn the next E slot into a bubble.
  always_comb begin
    e_md_op_d = MD_NONE;
    if (e_flush || stall_d) begin
      e_md_op_d = MD_NONE;
    end else if (d_valid) begin
      e_md_op_d = d_md_op;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = is_md_div(e_md_op_q) ? CNT_W'(LAT_DIV) : CNT_W'(LAT_MULT);
    case (state_q)
      ST_IDLE: begin
        if (e_start) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A start seen while running can only come from a broken stall path.
  assign busy_mismatch_d = busy_mismatch_q | (mdu_busy != shadow_busy) | (e_start & run);
  assign stall_cnt_d     = (stall_d && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_op_q       <= MD_NONE;
      state_q         <= ST_IDLE;
      busy_mismatch_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      e_md_op_q       <= e_md_op_d;
      state_q         <= state_d;
      busy_mismatch_q <= busy_mismatch_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign busy_mismatch = busy_mismatch_q;
  assign stall_cnt     = stall_cnt_q;

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) u_shadow_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .last_o    (cnt_last)
  );

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Initiator-side controller for the multiply/divide unit (MDU) in the 5-stage pipelined CPU.
- Registers the decoded MD-class operation from D into the E-stage MD slot and drives the MDU start request.
- Keeps a shadow busy counter that mirrors MDU latency, produces the D-stage stall for HI/LO hazards, and checks the MDU's busy output against the shadow.
- Counts stall cycles for performance monitoring.

Parameters:
- LAT_MULT, 5, busy cycles after a mult/multu start.
- LAT_DIV, 10, busy cycles after a div/divu start.
- CNT_W, 4, shadow counter width; must hold LAT_DIV.
- PERF_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_md_op  in  4  decoded MD op of the D-stage instruction (package encoding).
- d_valid  in  1  D-stage instruction is valid.
- e_flush  in  1  next E-slot content is forced to NONE.
- mdu_busy  in  1  busy output from the MDU.
- e_md_op  out  4  registered MD op in the E slot; the MDU consumes it.
- e_start  out  1  combinational: e_md_op is MULT, MULTU, DIV or DIVU.
- stall_d  out  1  combinational: freeze D and F, insert a bubble into E.
- shadow_busy  out  1  state==RUN.
- busy_mismatch  out  1  sticky: mdu_busy disagreed with shadow_busy.
- stall_cnt  out  PERF_W  saturating count of cycles with stall_d=1.

Behaviour:
- Reset (synchronous): e_md_op=NONE, state=IDLE, cnt=0, busy_mismatch=0, stall_cnt=0.
  - Consequently e_start=0, stall_d=0, shadow_busy=0.
- Op classes:
  - MD_ANY = ops 1..8.
  - MD_START = MULT, MULTU, DIV, DIVU.
- stall_d = d_valid & (d_md_op in MD_ANY) & (e_start | state==RUN).
- E-slot register update, each edge, in priority order:
  1. e_flush → NONE.
  2. stall_d → NONE (bubble).
  3. d_valid → d_md_op.
  4. otherwise → NONE.
- An op present in the E slot is committed; a flush never aborts an issued op or a running count.
- FSM states: IDLE, RUN.
  - IDLE, e_start=1: go to RUN; cnt ← LAT_MULT for MULT/MULTU, LAT_DIV for DIV/DIVU.
  - IDLE, e_start=0: stay in IDLE.
  - RUN, cnt>1: cnt ← cnt-1.
  - RUN, cnt==1: go to IDLE, cnt ← 0. The MDU writes HI/LO on this same edge.
  - e_start cannot be 1 while in RUN, because stall_d blocks that issue. If it occurs anyway, it is ignored and busy_mismatch is set.
- Timing: a start in cycle t gives shadow_busy=1 for cycles t+1 .. t+LAT; the first unstalled MD op in D is in cycle t+LAT+1.
- Mismatch check: every cycle after reset, if mdu_busy != shadow_busy, set busy_mismatch ← 1. It is cleared only by reset.
- stall_cnt increments on every stall_d cycle and saturates at all-ones.
- Non-MD ops (d_md_op=NONE) never stall and never enter the E slot as MD ops.
- Reset mid-operation: the FSM returns to IDLE immediately. The MDU is reset by the same signal.

Decomposition:
- Shared package (md_pkg) holds:
  - op encoding, 4-bit: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
  - classification functions is_md_any and is_md_start;
  - default latency constants.
- One sub-module, md_lat_counter: loadable down-counter with done flag, instantiated for the shadow counter.

Test Plan:
1. Reset, then MULT in D with no hazard → e_md_op=1 next cycle; e_start=1 that cycle; shadow_busy=1 for exactly 5 cycles after; stall_cnt=0.
2. MULT followed immediately by MFLO → MFLO stalled for 6 cycles (start cycle plus 5 RUN cycles); enters E in the cycle after shadow_busy falls; stall_cnt=6.
3. DIVU followed by MTHI, then ADD (NONE) → MTHI stalled for 11 cycles; the ADD is held behind it in D, because F and D are frozen; shadow_busy high for 10 cycles.
4. e_flush asserted in the cycle DIV reaches D with no stall → e_md_op=NONE next cycle; FSM stays IDLE.
   - Separately, flush while in RUN: count continues and completes after 10 cycles.
5. Mismatch: drive mdu_busy=0 during the 3rd RUN cycle of a MULT → busy_mismatch=1 and stays 1 through later ops until reset.
6. Reset asserted at cnt=7 of a DIV → next cycle state IDLE, shadow_busy=0, stall_d=0 for a pending MFHI; stall_cnt=0.
